// File: rtl/md_sequencer_if.sv
// E-stage multiply/divide sequencer bus: decode-side requests in, HI/LO control and stall out.
interface md_sequencer_if;
  logic       e_valid;
  logic [2:0] e_op;
  logic       e_divisor_zero;
  logic       d_md_use;
  logic       md_start;
  logic       md_signed;
  logic       md_is_div;
  logic       hi_we;
  logic       lo_we;
  logic       hilo_sel;
  logic       busy;
  logic       stall_d;

  modport master (
    output e_valid, e_op, e_divisor_zero, d_md_use,
    input  md_start, md_signed, md_is_div, hi_we, lo_we, hilo_sel, busy, stall_d
  );

  modport slave (
    input  e_valid, e_op, e_divisor_zero, d_md_use,
    output md_start, md_signed, md_is_div, hi_we, lo_we, hilo_sel, busy, stall_d
  );
endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: starts the HI/LO arithmetic unit, times its fixed latency,
// commits HI/LO at completion and stalls D-stage HI/LO users meanwhile.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic           clk,
  input  logic           reset,
  md_sequencer_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dz, dz_nxt;

  logic op_arith;
  logic op_signed;
  logic op_div;
  logic accept;

  // Opcode decode; reserved and none fall through as non-MD.
  always_comb begin
    op_arith  = (bus.e_op == OP_MULT) || (bus.e_op == OP_MULTU) ||
                (bus.e_op == OP_DIV)  || (bus.e_op == OP_DIVU);
    op_signed = (bus.e_op == OP_MULT) || (bus.e_op == OP_DIV);
    op_div    = (bus.e_op == OP_DIV)  || (bus.e_op == OP_DIVU);
    accept    = reset && (state == IDLE) && bus.e_valid && op_arith;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      dz    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dz    <= dz_nxt;
    end
  end

  // Next state and outputs; everything is forced low while reset is asserted.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    dz_nxt        = dz;
    bus.md_start  = 1'b0;
    bus.md_signed = 1'b0;
    bus.md_is_div = 1'b0;
    bus.hi_we     = 1'b0;
    bus.lo_we     = 1'b0;
    bus.hilo_sel  = 1'b0;
    bus.busy      = 1'b0;
    bus.stall_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          bus.md_start  = 1'b1;
          bus.md_signed = op_signed;
          bus.md_is_div = op_div;
          cnt_nxt       = op_div ? DIV_LOAD : MULT_LOAD;
          dz_nxt        = bus.e_divisor_zero && op_div;
          state_nxt     = RUN;
        end else if (bus.e_valid && (bus.e_op == OP_MTHI)) begin
          bus.hi_we    = 1'b1;
          bus.hilo_sel = 1'b1;
        end else if (bus.e_valid && (bus.e_op == OP_MTLO)) begin
          bus.lo_we    = 1'b1;
          bus.hilo_sel = 1'b1;
        end
      end
      RUN: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt <= CNT_ONE) begin
          state_nxt = WB;
        end
      end
      WB: begin
        // A zero divisor leaves HI/LO untouched.
        bus.hi_we = !dz;
        bus.lo_we = !dz;
        dz_nxt    = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    bus.busy    = (state != IDLE);
    bus.stall_d = bus.d_md_use && (bus.busy || accept);

    if (!reset) begin
      bus.md_start  = 1'b0;
      bus.md_signed = 1'b0;
      bus.md_is_div = 1'b0;
      bus.hi_we     = 1'b0;
      bus.lo_we     = 1'b0;
      bus.hilo_sel  = 1'b0;
      bus.busy      = 1'b0;
      bus.stall_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic checked against a cycle-timeline reference model.
module tb_md_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    bit       rst;
    bit       ev;
    bit [2:0] op;
    bit       dz;
    bit       use_d;
    bit [7:0] exp; // {start, signed, is_div, hi_we, lo_we, hilo_sel, busy, stall_d}
  } vec_t;

  logic clk;
  logic reset;
  md_sequencer_if bus();

  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] got;

  // Reference model: an op is a timeline of age 1..lat in flight, age lat+1 commits.
  bit m_act;
  int m_age;
  int m_lat;
  bit m_dz;

  function automatic bit [7:0] predict(input vec_t v);
    bit [7:0] e;
    bit is_arith;
    e = '0;
    if (!v.rst) return e;
    if (m_act) begin
      e[1] = 1'b1;
      e[0] = v.use_d;
      if (m_age == m_lat + 1 && !m_dz) begin
        e[4] = 1'b1;
        e[3] = 1'b1;
      end
    end else begin
      is_arith = v.ev && (v.op >= 3'd1) && (v.op <= 3'd4);
      if (is_arith) begin
        e[7] = 1'b1;
        e[6] = (v.op == 3'd1) || (v.op == 3'd3);
        e[5] = (v.op >= 3'd3);
        e[0] = v.use_d;
      end else if (v.ev && v.op == 3'd5) begin
        e[4] = 1'b1;
        e[2] = 1'b1;
      end else if (v.ev && v.op == 3'd6) begin
        e[3] = 1'b1;
        e[2] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_update(input vec_t v);
    if (!v.rst) begin
      m_act = 1'b0;
    end else if (m_act) begin
      m_age++;
      if (m_age > m_lat + 1) m_act = 1'b0;
    end else if (v.ev && v.op >= 3'd1 && v.op <= 3'd4) begin
      m_act = 1'b1;
      m_age = 1;
      m_lat = (v.op >= 3'd3) ? DIV_N : MULT_N;
      m_dz  = v.dz && (v.op >= 3'd3);
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst, input bit ev, input bit [2:0] op,
                              input bit dz, input bit use_d);
    vec_t v;
    v.rst = rst; v.ev = ev; v.op = op; v.dz = dz; v.use_d = use_d; v.exp = '0;
    return v;
  endfunction

  // One cycle: drive after the falling edge, sample mid-low-phase, advance the model after the rising edge.
  task automatic step(input vec_t v, input bit use_tab, input string name);
    bit [7:0] e;
    @(negedge clk);
    reset              = v.rst;
    bus.e_valid        = v.ev;
    bus.e_op           = v.op;
    bus.e_divisor_zero = v.dz;
    bus.d_md_use       = v.use_d;
    #2;
    got = {bus.md_start, bus.md_signed, bus.md_is_div, bus.hi_we,
           bus.lo_we, bus.hilo_sel, bus.busy, bus.stall_d};
    e = use_tab ? v.exp : predict(v);
    check(name, got, e);
    @(posedge clk);
    model_update(v);
  endtask

  vec_t tab[13];
  int   wr1, wr2;
  bit   any_we;

  initial begin
    reset = 1'b0;
    bus.e_valid = 1'b0; bus.e_op = 3'd0; bus.e_divisor_zero = 1'b0; bus.d_md_use = 1'b0;
    m_act = 1'b0; m_age = 0; m_lat = 0; m_dz = 1'b0;

    tab[0]  = '{rst:0, ev:1, op:1, dz:0, use_d:1, exp:8'b0000_0000};
    tab[1]  = '{rst:1, ev:1, op:1, dz:0, use_d:0, exp:8'b1100_0000};
    tab[2]  = '{rst:1, ev:0, op:0, dz:0, use_d:0, exp:8'b0000_0010};
    tab[3]  = '{rst:1, ev:1, op:6, dz:0, use_d:0, exp:8'b0000_0010};
    tab[4]  = '{rst:1, ev:1, op:1, dz:0, use_d:1, exp:8'b0000_0011};
    tab[5]  = '{rst:1, ev:0, op:0, dz:0, use_d:0, exp:8'b0000_0010};
    tab[6]  = '{rst:1, ev:0, op:0, dz:0, use_d:0, exp:8'b0000_0010};
    tab[7]  = '{rst:1, ev:0, op:0, dz:0, use_d:0, exp:8'b0001_1010};
    tab[8]  = '{rst:1, ev:1, op:5, dz:0, use_d:0, exp:8'b0001_0100};
    tab[9]  = '{rst:1, ev:1, op:6, dz:0, use_d:1, exp:8'b0000_1100};
    tab[10] = '{rst:1, ev:1, op:7, dz:0, use_d:1, exp:8'b0000_0000};
    tab[11] = '{rst:1, ev:0, op:3, dz:0, use_d:1, exp:8'b0000_0000};
    tab[12] = '{rst:1, ev:0, op:0, dz:0, use_d:0, exp:8'b0000_0000};

    foreach (tab[i]) step(tab[i], 1'b1, $sformatf("tab%0d", i));

    // divu, nonzero divisor, D-stage HI/LO user waiting throughout
    step(mk(1, 1, 4, 0, 1), 1'b0, "divu_c0");
    check("divu_start", got, 8'b1010_0001);
    for (int c = 1; c <= 12; c++) begin
      step(mk(1, 0, 0, 0, 1), 1'b0, $sformatf("divu_c%0d", c));
      if (c == 11) check("divu_wb", got, 8'b0001_1011);
      if (c == 12) check("divu_released", got, 8'b0000_0000);
    end

    // div by zero runs full latency but suppresses the commit
    step(mk(1, 1, 3, 1, 0), 1'b0, "divz_c0");
    for (int c = 1; c <= 12; c++) begin
      step(mk(1, 0, 0, 1, 0), 1'b0, $sformatf("divz_c%0d", c));
      if (c == 11) check("divz_wb", got, 8'b0000_0010);
    end

    // mult aborted by reset in cycle 3
    any_we = 1'b0;
    step(mk(1, 1, 1, 0, 1), 1'b0, "abort_c0");
    step(mk(1, 0, 0, 0, 1), 1'b0, "abort_c1");
    step(mk(1, 0, 0, 0, 1), 1'b0, "abort_c2");
    step(mk(0, 1, 5, 0, 1), 1'b0, "abort_c3");
    check("abort_zero", got, 8'b0000_0000);
    step(mk(0, 1, 1, 0, 1), 1'b0, "abort_c4");
    for (int c = 5; c <= 13; c++) begin
      step(mk(1, 0, 0, 0, 1), 1'b0, $sformatf("abort_c%0d", c));
      any_we |= got[4] | got[3];
    end
    check("abort_nowr", {7'd0, any_we}, 8'd0);

    // back-to-back: multu at 0, divu at 7
    wr1 = -1; wr2 = -1;
    for (int c = 0; c <= 19; c++) begin
      if (c == 0)      step(mk(1, 1, 2, 0, 0), 1'b0, "b2b_c0");
      else if (c == 7) step(mk(1, 1, 4, 0, 0), 1'b0, "b2b_c7");
      else             step(mk(1, 0, 0, 0, 0), 1'b0, $sformatf("b2b_c%0d", c));
      if (c == 7) check("b2b_start2", got, 8'b1010_0000);
      if (got[4] && wr1 < 0) wr1 = c;
      else if (got[4]) wr2 = c;
    end
    check("b2b_wr1", 8'(wr1), 8'd6);
    check("b2b_wr2", 8'(wr2), 8'd18);

    // randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      vec_t v;
      v = mk(($urandom_range(0, 59) != 0), 1'($urandom), 3'($urandom),
             ($urandom_range(0, 3) == 0), 1'($urandom));
      step(v, 1'b0, $sformatf("rand_c%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide sequencer for the E stage of the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo from the E-stage decode and pulses a start to the external HI/LO arithmetic unit. It counts the fixed operation latency, issues the HI/LO write enables at completion, and raises the D-stage stall that keeps any following HI/LO instruction out of E until the result is committed.

## Interface
- MULT_CYCLES, 5, multiply latency in cycles (1..15)
- DIV_CYCLES, 10, divide latency in cycles (1..15)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- e_valid  in  1  E-stage holds a real instruction (not a bubble)
- e_op  in  3  E-stage MD opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- e_divisor_zero  in  1  rt operand of the E-stage instruction equals 0
- d_md_use  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- md_start  out  1  one-cycle start pulse to the arithmetic unit
- md_signed  out  1  operation is signed (mult/div); valid with md_start
- md_is_div  out  1  operation is divide; valid with md_start
- hi_we  out  1  write HI this cycle
- lo_we  out  1  write LO this cycle
- hilo_sel  out  1  write source: 0 arithmetic result, 1 rs operand (mthi/mtlo)
- busy  out  1  an arithmetic operation is in flight
- stall_d  out  1  freeze F/D and bubble E

## Operation
- States: IDLE, RUN, WB. Counter cnt (CNT_W bits), flag dz (divide-by-zero latched).
- accept = (state==IDLE) & e_valid & e_op in {1,2,3,4}.
- IDLE: on accept, md_start=1 (combinational), md_signed = op in {1,3}, md_is_div = op in {3,4}. Load cnt = MULT_CYCLES or DIV_CYCLES. Latch dz = e_divisor_zero & md_is_div. Go to RUN.
- IDLE, e_valid and e_op=5: hi_we=1, hilo_sel=1, same cycle; no state change. e_op=6: lo_we=1, hilo_sel=1.
- RUN: cnt decrements each cycle; when cnt==1, go to WB.
- WB: hi_we=lo_we=1, hilo_sel=0, unless dz=1, in which case both stay 0 (HI/LO keep prior values); go to IDLE.
- busy = (state != IDLE).
- stall_d = d_md_use & (busy | accept).
- MD opcodes presented in E while not IDLE are a protocol violation: they are ignored (no start, no writes, no state effect).
- md_signed/md_is_div are 0 whenever md_start is 0.

## Timing
- Reset low: state=IDLE, cnt=0, dz=0; every output 0 regardless of inputs. Asserting reset mid-operation aborts it; no HI/LO write occurs.
- Accept in cycle 0: md_start in cycle 0; RUN in cycles 1..N (N = selected latency); WB in cycle N+1; IDLE in cycle N+2.
- busy is high in cycles 1..N+1.
- stall_d is high in cycles 0..N+1 whenever d_md_use is high. The stalled instruction enters E in cycle N+2 and mfhi/mflo there sees the committed HI/LO.
- Non-MD instructions are never stalled by this block.
- mthi/mtlo: zero latency, no busy, no stall.
- A new accept is possible in cycle N+2 (back-to-back, no gap cycle beyond WB).
- Outputs other than state-derived busy and the WB enables are combinational from inputs and state.

## Test plan
- Reset low with e_valid=1, e_op=1 -> all outputs 0. Release reset, IDLE, e_op=1 -> md_start=1, md_signed=1, md_is_div=0 in cycle 0; busy cycles 1..6; hi_we=lo_we=1, hilo_sel=0 in cycle 6 only.
- divu with divisor nonzero, d_md_use=1 throughout -> stall_d cycles 0..11, busy 1..11, write enables in cycle 11, stall_d=0 in cycle 12.
- div with e_divisor_zero=1 -> full latency; busy 1..11; hi_we=lo_we=0 in cycle 11.
- mthi in IDLE -> hi_we=1, hilo_sel=1, lo_we=0 same cycle, busy stays 0. mtlo presented during RUN -> ignored, no write enables.
- mult accepted, reset driven low in cycle 3 -> outputs 0 immediately. Release reset -> IDLE, no write enables ever issued for the aborted op.
- Back-to-back: multu at cycle 0, divu at cycle 7 -> second md_start in cycle 7 with md_signed=0, md_is_div=1; writes in cycles 6 and 18.
